// File: rtl/nzcv_pkg.sv
// Shared definitions for the NZCV condition unit: condition-code encoding,
// flag bit positions and statistics counter width.
package nzcv_pkg;

  // ARM-style 4-bit condition codes
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Bit positions inside a 4-bit NZCV vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Width of the optional executed/skipped op counters
  localparam int STATS_W = 16;

endpackage : nzcv_pkg

// File: rtl/nzcv_cond_eval.sv
// Combinational condition-code evaluator: decides whether an op with
// condition i_cond executes given the current NZCV flags.
module nzcv_cond_eval
  import nzcv_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_pass
);

  logic n_flag;
  logic z_flag;
  logic c_flag;
  logic v_flag;
  cond_e cond;

  assign n_flag = i_nzcv[FLAG_N];
  assign z_flag = i_nzcv[FLAG_Z];
  assign c_flag = i_nzcv[FLAG_C];
  assign v_flag = i_nzcv[FLAG_V];
  assign cond   = cond_e'(i_cond);

  // Condition table lookup
  always_comb begin
    // NOTE: a default assignment before the case keeps this block free of
    // inferred latches even if an arm is later removed.
    o_pass = 1'b0;
    unique case (cond)
      COND_EQ: o_pass = z_flag;
      COND_NE: o_pass = !z_flag;
      COND_CS: o_pass = c_flag;
      COND_CC: o_pass = !c_flag;
      COND_MI: o_pass = n_flag;
      COND_PL: o_pass = !n_flag;
      COND_VS: o_pass = v_flag;
      COND_VC: o_pass = !v_flag;
      COND_HI: o_pass = c_flag && !z_flag;
      COND_LS: o_pass = !c_flag || z_flag;
      COND_GE: o_pass = (n_flag == v_flag);
      COND_LT: o_pass = (n_flag != v_flag);
      COND_GT: o_pass = !z_flag && (n_flag == v_flag);
      COND_LE: o_pass = z_flag || (n_flag != v_flag);
      COND_AL: o_pass = 1'b1;
      COND_NV: o_pass = 1'b0;
      default: o_pass = 1'b0;
    endcase
  end

endmodule : nzcv_cond_eval

// File: rtl/nzcv_cond_unit.sv
// Architectural NZCV register plus a one-entry valid/ready output stage.
// Each accepted op is tagged with a write-enable (o_exec) computed from the
// flags as they stood before that op; flag-setting ops that execute update
// the register, and a direct MSR-style write overrides any op update.
// Optional macro NZCV_COND_STATS_EN adds saturating executed/skipped counters.
module nzcv_cond_unit
  import nzcv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [3:0]   i_cond,
  input  logic         i_set_flags,
  input  logic [3:0]   i_nzcv,
  input  logic [N-1:0] i_result,
  input  logic         i_flags_we,
  input  logic [3:0]   i_flags_wdata,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result,
  output logic         o_exec,
  output logic [3:0]   o_flags
`ifdef NZCV_COND_STATS_EN
  ,
  output logic [STATS_W-1:0] o_exec_cnt,
  output logic [STATS_W-1:0] o_skip_cnt
`endif
);

  logic [3:0] flags_q;
  logic       pass;
  logic       accept;

  nzcv_cond_eval u_cond_eval (
    .i_cond (i_cond),
    .i_nzcv (flags_q),
    .o_pass (pass)
  );

  // Single output register: free when empty or being drained this cycle
  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;
  assign o_flags = flags_q;

  // Output stage: capture on accept, drop when drained with nothing new
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the result datapath is reset too, so a dropped in-flight op
      // leaves no stale data visible on o_result after reset.
      o_valid  <= 1'b0;
      o_exec   <= 1'b0;
      o_result <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments let every register here sample the
      // pre-edge values, which is what makes pass see the old flags.
      o_valid  <= 1'b1;
      o_exec   <= pass;
      o_result <= i_result;
    end else if (i_ready) begin
      o_valid  <= 1'b0;
    end
  end

  // Architectural flag register: direct write has priority over op update
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flags_q <= 4'b0000;
    end else if (i_flags_we) begin
      flags_q <= i_flags_wdata;
    end else if (accept && pass && i_set_flags) begin
      flags_q <= i_nzcv;
    end
  end

`ifdef NZCV_COND_STATS_EN
  localparam logic [STATS_W-1:0] STATS_MAX = {STATS_W{1'b1}};

  // Saturating counters of executed and skipped accepted ops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_exec_cnt <= '0;
      o_skip_cnt <= '0;
    end else if (accept) begin
      if (pass) begin
        if (o_exec_cnt != STATS_MAX) o_exec_cnt <= o_exec_cnt + 1'b1;
      end else begin
        if (o_skip_cnt != STATS_MAX) o_skip_cnt <= o_skip_cnt + 1'b1;
      end
    end
  end
`endif

endmodule : nzcv_cond_unit

// File: doc/nzcv_cond_unit.md
Name: nzcv_cond_unit

Overview:
Consumer end of the ALU flag interface. Holds the architectural NZCV register fed by alu_nzcv's o_nzcv. Evaluates a 4-bit ARM-style condition code against that register for each operation offered over a valid/ready handshake. Sits between the ALU and register-file writeback; each op is presented with its ALU result and flags and leaves one cycle later with a write-enable decision.

Parameters:
N, 32, datapath width of i_result/o_result

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  upstream op valid
o_ready  out  1  upstream may transfer
i_cond  in  4  condition code of op
i_set_flags  in  1  op updates NZCV if executed
i_nzcv  in  4  flags from ALU for this op, [3]=N [2]=Z [1]=C [0]=V
i_result  in  N  ALU result for this op
i_flags_we  in  1  direct flag write (MSR-style)
i_flags_wdata  in  4  direct flag write data
o_valid  out  1  output op valid
i_ready  in  1  downstream accepts
o_result  out  N  registered result
o_exec  out  1  condition passed; writeback enable
o_flags  out  4  current architectural NZCV

Behaviour:
- Reset (async, i_rst_n=0): o_valid=0, o_exec=0, o_result=0, o_flags=4'b0000. o_ready is combinational: it is 1 whenever the output stage is empty, so it reads 1 during and after reset.
- o_ready = !o_valid || i_ready. This gives a single output register with no bubble on back-to-back ops.
- Accept = i_valid && o_ready. On accept:
  - o_result <= i_result, o_exec <= pass(i_cond, flags), o_valid <= 1.
  - pass is evaluated on the flag register value BEFORE this cycle's update.
- Latency: exactly 1 cycle from accept to o_valid.
- Output held stable while o_valid && !i_ready.
- If !accept && i_ready, o_valid <= 0.
- Flag update on accept when pass && i_set_flags: flags <= i_nzcv. A failed op never changes flags, even if i_set_flags=1.
- Flag update from i_flags_we: flags <= i_flags_wdata.
- Same cycle direct write and flag-setting op: direct write wins. The op's pass still uses the old flags; its o_exec is unaffected.
- Consecutive accepted ops see each other's flag updates, so no hazard stall exists.
- Condition table (pass=1 when):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0
- Reset mid-operation: in-flight output is dropped (o_valid=0) and flags are cleared. No partial update survives.
- o_flags is the flag register itself, with no extra delay.

Optional Feature:
Macro NZCV_COND_STATS_EN.
- Defined: adds outputs o_exec_cnt[15:0] and o_skip_cnt[15:0].
  - Each accepted op increments one of them: o_exec_cnt on pass, o_skip_cnt on fail.
  - Both counters saturate at 16'hffff and reset to 0.
- Not defined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package nzcv_pkg:
  - cond_e enum (EQ..NV, 4 bits)
  - flag index localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - STATS_W=16
- Sub-module nzcv_cond_eval: combinational, inputs i_cond and i_nzcv, output o_pass; implements the table above. One instance in nzcv_cond_unit.

Test Plan:
- Reset, then i_valid=1 cond=EQ with flags 0000 -> o_valid=1 next cycle, o_exec=0, o_flags=0000.
- Op1 cond=AL set_flags=1 i_nzcv=0100, then Op2 cond=EQ back-to-back -> o_flags=0100 after Op1, Op2 o_exec=1. Repeat Op2 with cond=NE -> o_exec=0.
- Flags 1001 (N=1, V=1) -> GE pass, LT fail, GT pass, LE fail. Flags 0110 -> HI fail, LS pass, NV always 0.
- Backpressure: i_ready=0 for 3 cycles with o_valid=1 and o_result=32'h0001_0000 -> o_ready=0, output stable, no new accept; i_ready=1 -> next op transfers.
- Same cycle i_flags_we=1 wdata=1000 and accepted op AL set_flags=1 i_nzcv=0010 -> o_flags=1000. Separately, failed op (cond=EQ, Z=0) with set_flags=1 -> flags unchanged.
- Assert i_rst_n=0 while o_valid=1 and flags=1111 -> o_valid=0 and o_flags=0000 immediately (async). With NZCV_COND_STATS_EN: 3 passes and 2 fails -> o_exec_cnt=3, o_skip_cnt=2.
